// File: rtl/vga_fb_pkg.sv
// Geometry, command codes and FSM states shared by the framebuffer writer
// and the scan-out reader.
package vga_fb_pkg;

   localparam int H_PIX          = 640;
   localparam int V_PIX          = 480;
   localparam int WORDS_PER_LINE = H_PIX / 16;
   localparam int VMEM_END       = (H_PIX * V_PIX / 16) - 1;

   typedef enum logic [1:0] {
      OP_PLOT = 2'b00,
      OP_XOR  = 2'b01,
      OP_WORD = 2'b10,
      OP_FILL = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_CAP,
      ST_WR_REQ,
      ST_GAP
   } state_t;

   // Leftmost pixel of a word sits in bit 15; scan-out shifts MSB first.
   function automatic logic [15:0] pix_mask(input logic [3:0] col);
      return 16'h8000 >> col;
   endfunction

endpackage

// File: rtl/vga_fb_addr.sv
// Pixel coordinate to SRAM word address, one-hot bit mask and range flag.
module vga_fb_addr
   import vga_fb_pkg::*;
#(
   parameter logic [17:0] FB_BASE = 18'd0
) (
   input  logic [9:0]  x,
   input  logic [8:0]  y,
   output logic [17:0] adr,
   output logic [15:0] mask,
   output logic        in_range
);

   logic [14:0] line_off;

   always_comb begin
      // y*40 without a multiplier; 479*40 still fits in 15 bits.
      line_off = ({6'd0, y} << 5) + ({6'd0, y} << 3);
      adr      = FB_BASE + {3'd0, line_off} + {12'd0, x[9:4]};
      mask     = pix_mask(x[3:0]);
      // x[9:4] < 40 is the same bound as x < 640, so pixel and word ops share it.
      in_range = (x[9:4] < 6'(WORDS_PER_LINE)) && (y < 9'(V_PIX));
   end

endmodule

// File: rtl/vga_fb_writer.sv
// CPU-side framebuffer write engine: PLOT/XOR via read-modify-write, WORD and
// FILL via plain writes, all over the shared request/grant SRAM port.
module vga_fb_writer
   import vga_fb_pkg::*;
#(
   parameter logic [17:0] FB_BASE = 18'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [9:0]  cmd_x,
   input  logic [8:0]  cmd_y,
   input  logic [15:0] cmd_data,
   output logic        err_oob,
   output logic [17:0] sram_adr,
   input  logic [15:0] sram_in,
   output logic [15:0] sram_dout,
   output logic        sram_we,
   output logic        data_rq,
   input  logic        grant
);

   state_t      state, state_nxt;
   op_t         op;
   logic        pix_val;
   logic [15:0] mask_q;
   logic [14:0] offset;
   logic [17:0] pix_adr;
   logic [15:0] pix_mask_w;
   logic        in_range;
   logic        xfer;
   logic        fill_more;
   logic [15:0] modified;

   vga_fb_addr #(.FB_BASE(FB_BASE)) u_addr (
      .x        (cmd_x),
      .y        (cmd_y),
      .adr      (pix_adr),
      .mask     (pix_mask_w),
      .in_range (in_range)
   );

   // Handshake and bus strobes decode straight from the state register.
   assign cmd_ready = (state == ST_IDLE);
   assign data_rq   = (state == ST_RD_REQ) || (state == ST_WR_REQ);
   assign sram_we   = (state == ST_WR_REQ);
   assign xfer      = cmd_valid && cmd_ready;
   assign fill_more = (op == OP_FILL) && (offset != 15'(VMEM_END));

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (xfer) begin
               if (cmd_op == OP_FILL)      state_nxt = ST_WR_REQ;
               else if (!in_range)         state_nxt = ST_IDLE;
               else if (cmd_op == OP_WORD) state_nxt = ST_WR_REQ;
               else                        state_nxt = ST_RD_REQ;
            end
         end
         ST_RD_REQ: if (grant) state_nxt = ST_RD_CAP;
         ST_RD_CAP: state_nxt = ST_WR_REQ;
         ST_WR_REQ: if (grant) state_nxt = fill_more ? ST_GAP : ST_IDLE;
         ST_GAP:    state_nxt = ST_WR_REQ;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      modified = sram_in ^ mask_q;
      if (op == OP_PLOT)
         modified = pix_val ? (sram_in | mask_q) : (sram_in & ~mask_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         op        <= OP_PLOT;
         pix_val   <= 1'b0;
         mask_q    <= 16'd0;
         offset    <= 15'd0;
         sram_adr  <= 18'd0;
         sram_dout <= 16'd0;
         err_oob   <= 1'b0;
      end else begin
         err_oob <= xfer && (cmd_op != OP_FILL) && !in_range;
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  op        <= op_t'(cmd_op);
                  pix_val   <= cmd_data[0];
                  mask_q    <= pix_mask_w;
                  offset    <= 15'd0;
                  sram_adr  <= (cmd_op == OP_FILL) ? FB_BASE : pix_adr;
                  sram_dout <= cmd_data;
               end
            end
            ST_RD_CAP: sram_dout <= modified;
            ST_WR_REQ: begin
               if (grant && fill_more) begin
                  offset   <= offset + 15'd1;
                  sram_adr <= sram_adr + 18'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/vga_fb_writer.md
# vga_fb_writer

Single-clock framebuffer write engine for the 640x480 monochrome display, 1 bpp, 16 pixels per 16-bit SRAM word. It sits on the CPU side of the shared SRAM arbiter, opposite the scan-out reader. It accepts pixel and word commands, converts (x,y) to word address and bit position, and performs arbitrated read-modify-write or plain write cycles over the same request/grant port the reader uses. A FILL command clears or patterns the whole framebuffer.

## Interface
- FB_BASE, 0: SRAM word address of pixel (0,0).
- H_PIX, 640: visible width; x >= H_PIX is out of range.
- V_PIX, 480: visible height; y >= V_PIX is out of range.
- WORDS_PER_LINE, 40: H_PIX/16.
- VMEM_END, 19199: last framebuffer word offset, (H_PIX*V_PIX/16)-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  high in IDLE only; a command transfers on cmd_valid && cmd_ready.
- cmd_op  in  2  00 PLOT, 01 XOR, 10 WORD, 11 FILL.
- cmd_x  in  10  pixel x. For WORD, only x[9:4] is used.
- cmd_y  in  9  pixel y. Ignored for FILL.
- cmd_data  in  16  PLOT: bit0 is the pixel value. WORD/FILL: the word to write. XOR: ignored.
- err_oob  out  1  one-cycle pulse when a command is dropped because x or y is out of range.
- sram_adr  out  18  access address, stable while data_rq is high.
- sram_in  in  16  read data, valid the cycle after a read grant.
- sram_dout  out  16  write data.
- sram_we  out  1  high only in WR_REQ.
- data_rq  out  1  access request.
- grant  in  1  the access happens in the cycle where data_rq && grant.

## Operation
- Address: word = FB_BASE + y*40 + x[9:4]. Compute y*40 as (y<<5)+(y<<3) in 15 bits, then add to 18 bits.
- Pixel position: bit = 15 - x[3:0]. The leftmost pixel is the MSB, because scan-out shifts bit 15 first.

FSM states:
- IDLE: cmd_ready=1. On transfer, latch op/x/y/data and the computed address.
  - PLOT/XOR out of range: set err_oob, stay in IDLE.
  - WORD out of range (y >= 480 or x[9:4] >= 40): set err_oob, stay in IDLE.
  - PLOT/XOR in range: go to RD_REQ.
  - WORD in range: go to WR_REQ with dout = data.
  - FILL: go to WR_REQ with adr = FB_BASE, dout = data.
- RD_REQ: data_rq=1, sram_we=0. On grant, go to RD_CAP.
- RD_CAP: data_rq=0. word = sram_in with the target bit set to data[0] (PLOT) or inverted (XOR). Go to WR_REQ.
- WR_REQ: data_rq=1, sram_we=1. On grant:
  - PLOT/XOR/WORD: go to IDLE.
  - FILL: if offset == VMEM_END, go to IDLE. Otherwise offset+1 and go to GAP.
- GAP: data_rq=0. Go to WR_REQ.

Rules:
- One access per grant. data_rq is low for at least one cycle after every granted cycle, so the arbiter can serve scan-out between FILL words.
- grant while data_rq=0 is ignored.
- grant held high continuously still yields exactly one access per request state entry.
- A new command is never accepted while busy.

## Timing
- Reset values: cmd_ready=1, data_rq=0, sram_we=0, sram_adr=0, sram_dout=0, err_oob=0, state IDLE.
- Reset mid-operation: return to IDLE next edge. No further request is issued, and a pending modify is discarded.
- All outputs are registered or decoded from registered state. There is no combinational path from grant to data_rq.
- PLOT/XOR with immediate grants: transfer at T0, RD_REQ granted T1, RD_CAP T2, write granted T3, cmd_ready=1 at T4. Each cycle of grant delay extends this by one.
- WORD: transfer T0, write granted T1, cmd_ready at T2.
- FILL: 2 cycles per word minimum, 38400 cycles plus grant stalls. The last write is to FB_BASE+19199.
- err_oob is asserted T1 only; cmd_ready stays 1.

## Structure
- Package vga_fb_pkg:
  - H_PIX, V_PIX, WORDS_PER_LINE, VMEM_END.
  - cmd_op codes (OP_PLOT, OP_XOR, OP_WORD, OP_FILL).
  - FSM state enum.
  - The scan-out block imports the same geometry constants.
- Sub-module vga_fb_addr (combinational): (x,y) in; word address, 16-bit one-hot bit mask and range flag out. Shared with future read-back logic.

## Test plan
- Reset, then PLOT x=17,y=2,data=1 with sram word 0x0000, immediate grant.
  - Read at adr 81, write 0x4000 to adr 81.
  - cmd_ready returns on T4.
- XOR x=0,y=0 with sram word 0xFFFF, grant delayed 3 cycles each access: write 0x7FFF to adr 0, and data_rq drops for exactly one cycle between the read and the write.
- WORD x=639,y=479,data=0xA5A5: single write 0xA5A5 to adr 19199, no read issued.
- PLOT x=640,y=0 and PLOT x=0,y=480: no data_rq, err_oob pulses once for each, and memory is unchanged.
- FILL data=0x0000 with a random grant pattern:
  - Exactly 19200 writes, addresses 0..19199 in order.
  - No two consecutive data_rq-high cycles both granted.
- FILL interrupted by rst low at word 100: data_rq=0 next cycle, cmd_ready=1 after release, and no write beyond word 100.
